// File: rtl/cache_tag_lookup_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cache_tag_lookup_if                                             |
// | Purpose  : Request/response, fill and flush signals of the tag lookup.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface cache_tag_lookup_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int N_WAYS     = 2,
   parameter int BLOCK_SIZE = 128,
   parameter int NUM_SETS   = 32
);
   localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);
   localparam int INDEX_BITS  = $clog2(NUM_SETS);
   localparam int TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
   localparam int WAY_BITS    = $clog2(N_WAYS);

   logic                   req_valid;
   logic                   req_ready;
   logic [ADDR_WIDTH-1:0]  req_addr;
   logic                   resp_valid;
   logic                   resp_ready;
   logic                   resp_hit;
   logic [WAY_BITS-1:0]    resp_way;
   logic [WAY_BITS-1:0]    resp_victim;
   logic [TAG_BITS-1:0]    resp_tag;
   logic [INDEX_BITS-1:0]  resp_index;
   logic [OFFSET_BITS-1:0] resp_offset;
   logic                   fill_valid;
   logic                   fill_ready;
   logic [ADDR_WIDTH-1:0]  fill_addr;
   logic                   flush_req;
   logic                   flush_busy;
   logic                   flush_done;

   modport master (
      output req_valid, req_addr, resp_ready, fill_valid, fill_addr, flush_req,
      input  req_ready, resp_valid, resp_hit, resp_way, resp_victim, resp_tag,
             resp_index, resp_offset, fill_ready, flush_busy, flush_done
   );

   modport slave (
      input  req_valid, req_addr, resp_ready, fill_valid, fill_addr, flush_req,
      output req_ready, resp_valid, resp_hit, resp_way, resp_victim, resp_tag,
             resp_index, resp_offset, fill_ready, flush_busy, flush_done
   );
endinterface
`default_nettype wire

// File: rtl/cache_tag_lookup.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cache_tag_lookup                                                |
// | Purpose  : N-way set-associative tag store, 1-cycle lookup, fills, flush.  |
// |            Define CACHE_TAG_LRU_EN for true LRU, else round-robin victims. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module cache_tag_lookup #(
   parameter int ADDR_WIDTH = 32,
   parameter int N_WAYS     = 2,
   parameter int BLOCK_SIZE = 128,
   parameter int NUM_SETS   = 32
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   cache_tag_lookup_if.slave  bus
);
   localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);
   localparam int INDEX_BITS  = $clog2(NUM_SETS);
   localparam int TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
   localparam int WAY_BITS    = $clog2(N_WAYS);

   localparam logic [INDEX_BITS-1:0] c_last_set = INDEX_BITS'(NUM_SETS - 1);
   localparam logic [INDEX_BITS-1:0] c_done_set = INDEX_BITS'(NUM_SETS - 2);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

`ifdef CACHE_TAG_LRU_EN
   // Per-way age, 0 = youngest.
   typedef logic [N_WAYS-1:0][WAY_BITS-1:0] repl_t;
`else
   typedef logic [WAY_BITS-1:0] repl_t;
`endif

   state_t                 r_state;
   logic [INDEX_BITS-1:0]  r_flush_cnt;
   logic                   r_flush_busy;
   logic                   r_flush_done;
   logic                   r_resp_valid;
   logic                   r_resp_hit;
   logic [WAY_BITS-1:0]    r_resp_way;
   logic [WAY_BITS-1:0]    r_resp_victim;
   logic [TAG_BITS-1:0]    r_resp_tag;
   logic [INDEX_BITS-1:0]  r_resp_index;
   logic [OFFSET_BITS-1:0] r_resp_offset;

   logic [N_WAYS-1:0]      r_valid [NUM_SETS];
   logic [TAG_BITS-1:0]    r_tag   [NUM_SETS][N_WAYS];
   repl_t                  r_repl  [NUM_SETS];

   logic                   w_req_ready;
   logic                   w_req_fire;
   logic                   w_fill_fire;
   logic [TAG_BITS-1:0]    w_req_tag;
   logic [INDEX_BITS-1:0]  w_req_index;
   logic [OFFSET_BITS-1:0] w_req_offset;
   logic [TAG_BITS-1:0]    w_fill_tag;
   logic [INDEX_BITS-1:0]  w_fill_index;
   logic                   w_req_hit;
   logic [WAY_BITS-1:0]    w_req_way;
   logic [WAY_BITS-1:0]    w_req_victim;
   logic                   w_fill_hit;
   logic [WAY_BITS-1:0]    w_fill_hit_way;
   logic [WAY_BITS-1:0]    w_fill_way;

   function automatic logic [WAY_BITS-1:0] f_victim(input logic [N_WAYS-1:0] valid,
                                                    input repl_t repl);
      logic [WAY_BITS-1:0] vic;
      logic                found;
`ifdef CACHE_TAG_LRU_EN
      vic = '0;
      for (int w = 1; w < N_WAYS; w++) begin
         if (repl[w] > repl[vic]) vic = WAY_BITS'(w);
      end
`else
      vic = repl;
`endif
      // An empty way always wins over the policy choice.
      found = 1'b0;
      for (int w = 0; w < N_WAYS; w++) begin
         if (!found && !valid[w]) begin
            vic   = WAY_BITS'(w);
            found = 1'b1;
         end
      end
      return vic;
   endfunction

`ifdef CACHE_TAG_LRU_EN
   function automatic repl_t f_touch(input repl_t repl, input logic [WAY_BITS-1:0] way);
      repl_t nxt;
      nxt = repl;
      for (int w = 0; w < N_WAYS; w++) begin
         if (WAY_BITS'(w) != way && repl[w] <= repl[way] && repl[w] != {WAY_BITS{1'b1}})
            nxt[w] = repl[w] + 1'b1;
      end
      nxt[way] = '0;
      return nxt;
   endfunction
`endif

   assign w_req_tag    = bus.req_addr[ADDR_WIDTH-1 -: TAG_BITS];
   assign w_req_index  = bus.req_addr[OFFSET_BITS +: INDEX_BITS];
   assign w_req_offset = bus.req_addr[OFFSET_BITS-1:0];
   assign w_fill_tag   = bus.fill_addr[ADDR_WIDTH-1 -: TAG_BITS];
   assign w_fill_index = bus.fill_addr[OFFSET_BITS +: INDEX_BITS];

   assign w_req_ready  = (r_state == ST_IDLE) && (!r_resp_valid || bus.resp_ready);
   assign w_req_fire   = bus.req_valid && w_req_ready;
   assign w_fill_fire  = bus.fill_valid && (r_state == ST_IDLE);

   // Downward scan so the lowest matching way wins.
   always_comb begin
      w_req_hit = 1'b0;
      w_req_way = '0;
      for (int w = N_WAYS - 1; w >= 0; w--) begin
         if (r_valid[w_req_index][w] && r_tag[w_req_index][w] == w_req_tag) begin
            w_req_hit = 1'b1;
            w_req_way = WAY_BITS'(w);
         end
      end
   end

   always_comb begin
      w_fill_hit     = 1'b0;
      w_fill_hit_way = '0;
      for (int w = N_WAYS - 1; w >= 0; w--) begin
         if (r_valid[w_fill_index][w] && r_tag[w_fill_index][w] == w_fill_tag) begin
            w_fill_hit     = 1'b1;
            w_fill_hit_way = WAY_BITS'(w);
         end
      end
   end

   assign w_req_victim = f_victim(r_valid[w_req_index], r_repl[w_req_index]);
   assign w_fill_way   = w_fill_hit ? w_fill_hit_way
                                    : f_victim(r_valid[w_fill_index], r_repl[w_fill_index]);

`ifdef CACHE_TAG_LRU_EN
   logic  w_req_touch;
   logic  w_same_set;
   repl_t w_req_repl_next;
   repl_t w_fill_repl_next;

   assign w_req_touch = w_req_fire && w_req_hit;
   assign w_same_set  = (w_req_index == w_fill_index);

   // A hit and a fill landing in the same set both age it, hit first.
   always_comb begin
      w_req_repl_next  = f_touch(r_repl[w_req_index], w_req_way);
      w_fill_repl_next = f_touch((w_req_touch && w_same_set) ? w_req_repl_next
                                                             : r_repl[w_fill_index],
                                 w_fill_way);
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            r_valid[s] <= '0;
            r_repl[s]  <= '0;
         end
      end else if (r_state == ST_FLUSH) begin
         r_valid[r_flush_cnt] <= '0;
         r_repl[r_flush_cnt]  <= '0;
      end else begin
`ifdef CACHE_TAG_LRU_EN
         if (w_req_touch && !(w_fill_fire && w_same_set))
            r_repl[w_req_index] <= w_req_repl_next;
         if (w_fill_fire)
            r_repl[w_fill_index] <= w_fill_repl_next;
`else
         if (w_fill_fire && !w_fill_hit)
            r_repl[w_fill_index] <= r_repl[w_fill_index] + 1'b1;
`endif
         if (w_fill_fire)
            r_valid[w_fill_index][w_fill_way] <= 1'b1;
      end
   end

   // Tag contents are qualified by the valid bits, so they need no reset.
   always_ff @(posedge clk) begin
      if (w_fill_fire)
         r_tag[w_fill_index][w_fill_way] <= w_fill_tag;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_flush_cnt   <= '0;
         r_flush_busy  <= 1'b0;
         r_flush_done  <= 1'b0;
         r_resp_valid  <= 1'b0;
         r_resp_hit    <= 1'b0;
         r_resp_way    <= '0;
         r_resp_victim <= '0;
         r_resp_tag    <= '0;
         r_resp_index  <= '0;
         r_resp_offset <= '0;
      end else begin
         r_flush_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.flush_req) begin
                  r_state      <= ST_FLUSH;
                  r_flush_cnt  <= '0;
                  r_flush_busy <= 1'b1;
               end
            end
            ST_FLUSH: begin
               r_flush_cnt <= r_flush_cnt + 1'b1;
               // Registered so the pulse lines up with the final set's cycle.
               if (r_flush_cnt == c_done_set)
                  r_flush_done <= 1'b1;
               if (r_flush_cnt == c_last_set) begin
                  r_state      <= ST_IDLE;
                  r_flush_busy <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         if (w_req_fire) begin
            r_resp_valid  <= 1'b1;
            r_resp_hit    <= w_req_hit;
            r_resp_way    <= w_req_way;
            r_resp_victim <= w_req_victim;
            r_resp_tag    <= w_req_tag;
            r_resp_index  <= w_req_index;
            r_resp_offset <= w_req_offset;
         end else if (bus.resp_ready) begin
            r_resp_valid  <= 1'b0;
         end
      end
   end

   assign bus.req_ready   = w_req_ready;
   assign bus.fill_ready  = (r_state == ST_IDLE);
   assign bus.resp_valid  = r_resp_valid;
   assign bus.resp_hit    = r_resp_hit;
   assign bus.resp_way    = r_resp_way;
   assign bus.resp_victim = r_resp_victim;
   assign bus.resp_tag    = r_resp_tag;
   assign bus.resp_index  = r_resp_index;
   assign bus.resp_offset = r_resp_offset;
   assign bus.flush_busy  = r_flush_busy;
   assign bus.flush_done  = r_flush_done;

endmodule
`default_nettype wire

// File: tb/tb_cache_tag_lookup.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cache_tag_lookup                                             |
// | Purpose  : Scoreboard bench for cache_tag_lookup at default parameters.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_cache_tag_lookup;
   typedef struct packed {
      logic        valid;
      logic        hit;
      logic        way;
      logic        victim;
      logic [19:0] tag;
      logic [4:0]  index;
      logic [6:0]  offset;
   } resp_t;

   logic   clk = 1'b0;
   logic   rst_n;
   int     vectors = 0;
   int     miscompares = 0;
   resp_t  q[$];

   cache_tag_lookup_if #(.ADDR_WIDTH(32), .N_WAYS(2), .BLOCK_SIZE(128), .NUM_SETS(32)) bus ();

   cache_tag_lookup #(.ADDR_WIDTH(32), .N_WAYS(2), .BLOCK_SIZE(128), .NUM_SETS(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic resp_t mk(input logic hit, input logic way, input logic victim,
                                input logic [31:0] a);
      resp_t r;
      r.valid  = 1'b1;
      r.hit    = hit;
      r.way    = way;
      r.victim = victim;
      r.tag    = a[31:12];
      r.index  = a[11:7];
      r.offset = a[6:0];
      return r;
   endfunction

   function automatic resp_t sample();
      return {bus.resp_valid, bus.resp_hit, bus.resp_way, bus.resp_victim,
              bus.resp_tag, bus.resp_index, bus.resp_offset};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [3:0] ctl;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      vectors++;
      if (sample() !== '0) begin
         miscompares++;
         $display("FAIL reset_resp: got %h, want 0", sample());
      end
      ctl = {bus.flush_busy, bus.flush_done, bus.req_ready, bus.fill_ready};
      vectors++;
      if (ctl !== 4'b0011) begin
         miscompares++;
         $display("FAIL reset_ctl: got %b, want 0011", ctl);
      end
   endtask

   task automatic test_miss_after_reset();
      resp_t act, exp;
      logic [31:0] fields;
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h1234_5680;
      q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h1234_5680));
      tick();
      bus.req_valid = 1'b0;
      act = sample();
      exp = q.pop_front();
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL miss_after_reset: got %h, want %h", act, exp);
      end
      fields = {act.tag, act.index, act.offset};
      vectors++;
      if (fields !== {20'h12345, 5'hD, 7'h00}) begin
         miscompares++;
         $display("FAIL addr_split: got %h, want %h", fields, {20'h12345, 5'hD, 7'h00});
      end
      tick();
   endtask

   task automatic test_fill_hit();
      resp_t act, exp;
      bus.fill_valid = 1'b1;
      bus.fill_addr  = 32'h1234_5680;
      tick();
      bus.fill_valid = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_addr   = 32'h1234_56FF;
      q.push_back(mk(1'b1, 1'b0, 1'b1, 32'h1234_56FF));
      tick();
      bus.req_valid = 1'b0;
      act = sample();
      exp = q.pop_front();
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL fill_hit: got %h, want %h", act, exp);
      end
      tick();
      vectors++;
      if (bus.resp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL fill_hit_drain: resp_valid got %b, want 0", bus.resp_valid);
      end
   endtask

   task automatic test_same_edge();
      resp_t act, exp;
      bus.fill_valid = 1'b1;
      bus.fill_addr  = 32'h2000_0100;
      bus.req_valid  = 1'b1;
      bus.req_addr   = 32'h2000_0100;
      q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h2000_0100));
      tick();
      bus.fill_valid = 1'b0;
      act = sample();
      exp = q.pop_front();
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL same_edge_miss: got %h, want %h", act, exp);
      end
      q.push_back(mk(1'b1, 1'b0, 1'b1, 32'h2000_0100));
      tick();
      bus.req_valid = 1'b0;
      act = sample();
      exp = q.pop_front();
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL same_edge_next_hit: got %h, want %h", act, exp);
      end
      tick();
   endtask

   task automatic test_replacement();
      logic [31:0] fa [3];
      logic [31:0] la [3];
      resp_t       le [3];
      resp_t       act, exp;
      fa[0] = 32'h0000_A180;
      fa[1] = 32'h0000_B180;
      fa[2] = 32'h0000_C180;
`ifdef CACHE_TAG_LRU_EN
      bus.fill_valid = 1'b1;
      bus.fill_addr  = fa[0];
      tick();
      bus.fill_addr  = fa[1];
      tick();
      bus.fill_valid = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_addr   = fa[0];
      q.push_back(mk(1'b1, 1'b0, 1'b0, fa[0]));
      tick();
      bus.req_valid  = 1'b0;
      act = sample();
      exp = q.pop_front();
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL lru_touch: got %h, want %h", act, exp);
      end
      bus.fill_valid = 1'b1;
      bus.fill_addr  = fa[2];
      tick();
      bus.fill_valid = 1'b0;
      la[0] = fa[0]; le[0] = mk(1'b1, 1'b0, 1'b0, fa[0]);
      la[1] = fa[2]; le[1] = mk(1'b1, 1'b1, 1'b1, fa[2]);
      la[2] = fa[1]; le[2] = mk(1'b0, 1'b0, 1'b0, fa[1]);
`else
      bus.fill_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.fill_addr = fa[i];
         tick();
      end
      bus.fill_valid = 1'b0;
      la[0] = fa[0]; le[0] = mk(1'b0, 1'b0, 1'b1, fa[0]);
      la[1] = fa[1]; le[1] = mk(1'b1, 1'b1, 1'b1, fa[1]);
      la[2] = fa[2]; le[2] = mk(1'b1, 1'b0, 1'b1, fa[2]);
`endif
      for (int i = 0; i < 3; i++) begin
         bus.req_valid = 1'b1;
         bus.req_addr  = la[i];
         q.push_back(le[i]);
         tick();
         act = sample();
         exp = q.pop_front();
         vectors++;
         if (act !== exp) begin
            miscompares++;
            $display("FAIL replacement[%0d]: got %h, want %h", i, act, exp);
         end
      end
      bus.req_valid = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] la [4];
      resp_t       le [4];
      resp_t       act, exp;
      la[0] = 32'h1234_5680; le[0] = mk(1'b1, 1'b0, 1'b1, la[0]);
      la[1] = 32'h2000_0100; le[1] = mk(1'b1, 1'b0, 1'b1, la[1]);
      la[2] = 32'h3000_0000; le[2] = mk(1'b0, 1'b0, 1'b0, la[2]);
      la[3] = 32'h1234_56FF; le[3] = mk(1'b1, 1'b0, 1'b1, la[3]);
      for (int i = 0; i < 4; i++) begin
         bus.req_valid = 1'b1;
         bus.req_addr  = la[i];
         q.push_back(le[i]);
         tick();
         act = sample();
         exp = q.pop_front();
         vectors++;
         if (act !== exp) begin
            miscompares++;
            $display("FAIL back_to_back[%0d]: got %h, want %h", i, act, exp);
         end
      end
      bus.req_valid = 1'b0;
      tick();
      vectors++;
      if (bus.resp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL back_to_back_drain: resp_valid got %b, want 0", bus.resp_valid);
      end
   endtask

   task automatic test_backpressure();
      resp_t act, exp;
      bus.resp_ready = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_addr   = 32'h1234_5680;
      q.push_back(mk(1'b1, 1'b0, 1'b1, 32'h1234_5680));
      tick();
      bus.req_addr = 32'h2000_0100;
      for (int i = 0; i < 4; i++) begin
         act = sample();
         vectors++;
         if (act !== q[0] || bus.req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure_hold[%0d]: got %h rdy %b, want %h rdy 0",
                     i, act, bus.req_ready, q[0]);
         end
         if (i < 3) tick();
      end
      bus.resp_ready = 1'b1;
      #1;
      vectors++;
      if (bus.req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL backpressure_release: req_ready got %b, want 1", bus.req_ready);
      end
      exp = q.pop_front();
      q.push_back(mk(1'b1, 1'b0, 1'b1, 32'h2000_0100));
      tick();
      bus.req_valid = 1'b0;
      act = sample();
      exp = q.pop_front();
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL backpressure_next: got %h, want %h", act, exp);
      end
      tick();
   endtask

   task automatic test_flush();
      logic [3:0]  ctl;
      logic [31:0] la [3];
      resp_t       act, exp;
      bus.flush_req = 1'b1;
      tick();
      bus.flush_req = 1'b0;
      for (int i = 0; i < 32; i++) begin
         ctl = {bus.flush_busy, bus.flush_done, bus.req_ready, bus.fill_ready};
         vectors++;
         if (ctl !== {1'b1, (i == 31), 2'b00}) begin
            miscompares++;
            $display("FAIL flush_cycle[%0d]: got %b, want %b", i, ctl, {1'b1, (i == 31), 2'b00});
         end
         tick();
      end
      ctl = {bus.flush_busy, bus.flush_done, bus.req_ready, bus.fill_ready};
      vectors++;
      if (ctl !== 4'b0011) begin
         miscompares++;
         $display("FAIL flush_end: got %b, want 0011", ctl);
      end
      la[0] = 32'h1234_5680;
      la[1] = 32'h0000_B180;
      la[2] = 32'h2000_0100;
      for (int i = 0; i < 3; i++) begin
         bus.req_valid = 1'b1;
         bus.req_addr  = la[i];
         q.push_back(mk(1'b0, 1'b0, 1'b0, la[i]));
         tick();
         act = sample();
         exp = q.pop_front();
         vectors++;
         if (act !== exp) begin
            miscompares++;
            $display("FAIL post_flush_miss[%0d]: got %h, want %h", i, act, exp);
         end
      end
      bus.req_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_flush();
      logic [3:0] ctl;
      resp_t      act;
      int         done_seen;
      bus.resp_ready = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_addr   = 32'h1234_5680;
      bus.flush_req  = 1'b1;
      q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h1234_5680));
      tick();
      bus.req_valid = 1'b0;
      bus.flush_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         act = sample();
         vectors++;
         if (act !== q[0] || bus.flush_busy !== 1'b1 || bus.flush_done !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_pending_hold[%0d]: got %h busy %b done %b, want %h busy 1 done 0",
                     i, act, bus.flush_busy, bus.flush_done, q[0]);
         end
         tick();
      end
      rst_n = 1'b0;
      #1;
      void'(q.pop_front());
      vectors++;
      if (sample() !== '0) begin
         miscompares++;
         $display("FAIL mid_flush_reset_resp: got %h, want 0", sample());
      end
      ctl = {bus.flush_busy, bus.flush_done, bus.req_ready, bus.fill_ready};
      vectors++;
      if (ctl !== 4'b0011) begin
         miscompares++;
         $display("FAIL mid_flush_reset_ctl: got %b, want 0011", ctl);
      end
      tick();
      rst_n = 1'b1;
      bus.resp_ready = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.flush_done !== 1'b0 || bus.flush_busy !== 1'b0) done_seen++;
         tick();
      end
      vectors++;
      if (done_seen !== 0) begin
         miscompares++;
         $display("FAIL mid_flush_no_done: got %0d busy/done cycles, want 0", done_seen);
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_addr   = '0;
      bus.resp_ready = 1'b1;
      bus.fill_valid = 1'b0;
      bus.fill_addr  = '0;
      bus.flush_req  = 1'b0;
      test_reset();
      test_miss_after_reset();
      test_fill_hit();
      test_same_edge();
      test_replacement();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_reset_mid_flush();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
